// File: rtl/pipe_fetch_ctrl_if.sv
// rtl/pipe_fetch_ctrl_if.sv - instruction-memory request/response handshake bundle
interface pipe_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pipe_fetch_ctrl.sv
// rtl/pipe_fetch_ctrl.sv - IF sequencer: PC, IF/ID register, stall hold buffer; counters under FETCH_CTRL_PERF_EN
module pipe_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    input  logic [1:0]              pcsource_i,
    input  logic [31:0]             bpc_i,
    input  logic [31:0]             da_i,
    input  logic [31:0]             jpc_i,
    input  logic                    stall_i,
    pipe_fetch_ctrl_if.master       imem,
    output logic [31:0]             pc_o,
    output logic [31:0]             dpc4_o,
    output logic [31:0]             dinst_o,
    output logic                    dvalid_o,
    output logic                    fetch_busy_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_fetched_o,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_squash_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_q, pend_d;
    logic        kill_q, kill_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] dinst_q, dinst_d;
    logic        dvalid_q, dvalid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic        hold_kill_q, hold_kill_d;
    logic        req_q, req_d;

    logic        redir;
    logic        squash;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q, perf_squash_q;
    logic        wr_valid, wr_squash;
`endif

    assign redir    = (pcsource_i != 2'b00) && !stall_i;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        target = jpc_i;
        case (pcsource_i)
            2'b01:   target = bpc_i;
            2'b10:   target = da_i;
            default: target = jpc_i;
        endcase
    end

    // A pending redirect (taken while memory was busy) wins over pc+4 once the fetch lands.
    assign next_pc = redir ? target : (pend_q ? pend_target_q : pc_plus4);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_d        = pend_q;
        kill_d        = kill_q;
        dpc4_d        = dpc4_q;
        dinst_d       = dinst_q;
        dvalid_d      = dvalid_q;
        hold_inst_d   = hold_inst_q;
        hold_pc4_d    = hold_pc4_q;
        hold_kill_d   = hold_kill_q;
        squash        = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
        wr_valid      = 1'b0;
        wr_squash     = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ready && !stall_i) begin
                    squash   = kill_q || (redir && pcsource_i[0]);
                    dpc4_d   = pc_plus4;
                    dinst_d  = squash ? NOP : imem.imem_rdata;
                    dvalid_d = !squash;
                    pc_d     = next_pc;
                    pend_d   = 1'b0;
                    kill_d   = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
                    wr_valid  = !squash;
                    wr_squash = squash;
`endif
                end else if (imem.imem_ready) begin
                    hold_inst_d = imem.imem_rdata;
                    hold_pc4_d  = pc_plus4;
                    hold_kill_d = kill_q;
                    state_d     = S_HOLD;
                end else if (!stall_i) begin
                    dpc4_d   = 32'd0;
                    dinst_d  = NOP;
                    dvalid_d = 1'b0;
                    if (redir) begin
                        pend_d        = 1'b1;
                        pend_target_d = target;
                        kill_d        = pcsource_i[0];
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    squash   = hold_kill_q || (redir && pcsource_i[0]);
                    dpc4_d   = hold_pc4_q;
                    dinst_d  = squash ? NOP : hold_inst_q;
                    dvalid_d = !squash;
                    pc_d     = next_pc;
                    pend_d   = 1'b0;
                    kill_d   = 1'b0;
                    state_d  = S_FETCH;
`ifdef FETCH_CTRL_PERF_EN
                    wr_valid  = !squash;
                    wr_squash = squash;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            pend_target_q  <= 32'd0;
            pend_q         <= 1'b0;
            kill_q         <= 1'b0;
            dpc4_q         <= 32'd0;
            dinst_q        <= NOP;
            dvalid_q       <= 1'b0;
            hold_inst_q    <= NOP;
            hold_pc4_q     <= 32'd0;
            hold_kill_q    <= 1'b0;
            req_q          <= 1'b0;
`ifdef FETCH_CTRL_PERF_EN
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
            perf_squash_q  <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_target_q  <= pend_target_d;
            pend_q         <= pend_d;
            kill_q         <= kill_d;
            dpc4_q         <= dpc4_d;
            dinst_q        <= dinst_d;
            dvalid_q       <= dvalid_d;
            hold_inst_q    <= hold_inst_d;
            hold_pc4_q     <= hold_pc4_d;
            hold_kill_q    <= hold_kill_d;
            req_q          <= req_d;
`ifdef FETCH_CTRL_PERF_EN
            if (wr_valid)  perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall_i)   perf_stall_q   <= perf_stall_q + 32'd1;
            if (wr_squash) perf_squash_q  <= perf_squash_q + 32'd1;
`endif
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc_o           = pc_q;
    assign dpc4_o         = dpc4_q;
    assign dinst_o        = dinst_q;
    assign dvalid_o       = dvalid_q;
    assign fetch_busy_o   = (state_q == S_FETCH) && !imem.imem_ready;
`ifdef FETCH_CTRL_PERF_EN
    assign perf_fetched_o = perf_fetched_q;
    assign perf_stall_o   = perf_stall_q;
    assign perf_squash_o  = perf_squash_q;
`endif

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// tb/tb_pipe_fetch_ctrl.sv - directed vector bench for pipe_fetch_ctrl
module tb_pipe_fetch_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] tgt = 32'd0;
    logic        stall = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] pc, dpc4, dinst;
    logic        dvalid, fetch_busy;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_squash;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int req_at_24 = 0;

    pipe_fetch_ctrl_if imem ();

    // ROM[i] = i + 0x100, indexed by word
    assign imem.imem_rdata = (imem.imem_addr >> 2) + 32'h100;
    assign imem.imem_ready = ready;

    always #5 clock = ~clock;

    pipe_fetch_ctrl dut (
        .clock_i      (clock),
        .resetn_i     (resetn),
        .pcsource_i   (pcsource),
        .bpc_i        (tgt),
        .da_i         (tgt),
        .jpc_i        (tgt),
        .stall_i      (stall),
        .imem         (imem),
        .pc_o         (pc),
        .dpc4_o       (dpc4),
        .dinst_o      (dinst),
        .dvalid_o     (dvalid),
        .fetch_busy_o (fetch_busy)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetched_o (perf_fetched),
        .perf_stall_o   (perf_stall),
        .perf_squash_o  (perf_squash)
`endif
    );

    always @(posedge clock)
        if (resetn && imem.imem_req && imem.imem_ready && imem.imem_addr == 32'h24)
            req_at_24++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic [1:0]  pcs;
        logic [31:0] tgt;
        logic        ready;
        logic [31:0] e_dinst;
        logic [31:0] e_dpc4;
        logic        e_dvalid;
        logic [31:0] e_addr;
        logic        e_req;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h0,   32'h0,   1'b0, 32'h0,   1'b1};
        vecs[1]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h100, 32'h4,   1'b1, 32'h4,   1'b1};
        vecs[2]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h101, 32'h8,   1'b1, 32'h8,   1'b1};
        vecs[3]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h102, 32'hC,   1'b1, 32'hC,   1'b1};
        vecs[4]  = '{1'b0, 2'b01, 32'h40,  1'b1, 32'h0,   32'h10,  1'b0, 32'h40,  1'b1};
        vecs[5]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h110, 32'h44,  1'b1, 32'h44,  1'b1};
        vecs[6]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h111, 32'h48,  1'b1, 32'h48,  1'b1};
        vecs[7]  = '{1'b0, 2'b10, 32'h100, 1'b1, 32'h112, 32'h4C,  1'b1, 32'h100, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h140, 32'h104, 1'b1, 32'h104, 1'b1};
        vecs[9]  = '{1'b0, 2'b11, 32'h20,  1'b1, 32'h0,   32'h108, 1'b0, 32'h20,  1'b1};
        vecs[10] = '{1'b0, 2'b00, 32'h0,   1'b1, 32'h108, 32'h24,  1'b1, 32'h24,  1'b1};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_dvalid", {31'd0, dvalid}, 32'd0);
        chk("reset_dinst", dinst, 32'h0);
        chk("reset_dpc4", dpc4, 32'h0);
        chk("reset_req", {31'd0, imem.imem_req}, 32'd0);
        resetn = 1'b1;
        chk("idle_req", {31'd0, imem.imem_req}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            stall = vecs[i].stall;
            pcsource = vecs[i].pcs;
            tgt = vecs[i].tgt;
            ready = vecs[i].ready;
            step();
            chk($sformatf("v%0d_dinst", i), dinst, vecs[i].e_dinst);
            chk($sformatf("v%0d_dpc4", i), dpc4, vecs[i].e_dpc4);
            chk($sformatf("v%0d_dvalid", i), {31'd0, dvalid}, {31'd0, vecs[i].e_dvalid});
            chk($sformatf("v%0d_addr", i), imem.imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_req", i), {31'd0, imem.imem_req}, {31'd0, vecs[i].e_req});
        end
        pcsource = 2'b00;
        tgt = 32'd0;

        // stall with data returned: held in buffer, no refetch
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_req", {31'd0, imem.imem_req}, 32'd0);
            chk("stall_dinst", dinst, 32'h108);
            chk("stall_dpc4", dpc4, 32'h24);
        end
        stall = 1'b0;
        step();
        chk("unstall_dinst", dinst, 32'h109);
        chk("unstall_dpc4", dpc4, 32'h28);
        chk("unstall_dvalid", {31'd0, dvalid}, 32'd1);
        chk("unstall_addr", imem.imem_addr, 32'h28);
        chk("single_req_24", req_at_24, 32'd1);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_stall", perf_stall, 32'd3);
`endif

        // jump while memory is waiting
        ready = 1'b0;
        pcsource = 2'b11;
        tgt = 32'h200;
        step();
        chk("wait_addr0", imem.imem_addr, 32'h28);
        chk("wait_busy", {31'd0, fetch_busy}, 32'd1);
        chk("wait_dvalid", {31'd0, dvalid}, 32'd0);
        pcsource = 2'b00;
        tgt = 32'd0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk("wait_addr", imem.imem_addr, 32'h28);
            chk("wait_req", {31'd0, imem.imem_req}, 32'd1);
        end
        ready = 1'b1;
        step();
        chk("wait_sq_dvalid", {31'd0, dvalid}, 32'd0);
        chk("wait_sq_dinst", dinst, 32'h0);
        chk("wait_sq_dpc4", dpc4, 32'h2C);
        chk("wait_next_addr", imem.imem_addr, 32'h200);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_squash", perf_squash, 32'd3);
`endif
        step();
        chk("tgt_dinst", dinst, 32'h180);
        chk("tgt_dpc4", dpc4, 32'h204);
        chk("tgt_dvalid", {31'd0, dvalid}, 32'd1);

        // PC wrap at top of address space
        pcsource = 2'b11;
        tgt = 32'hFFFF_FFFC;
        step();
        chk("wrap_jump_addr", imem.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_jump_dvalid", {31'd0, dvalid}, 32'd0);
        pcsource = 2'b00;
        tgt = 32'd0;
        step();
        chk("wrap_dinst", dinst, 32'h4000_00FF);
        chk("wrap_dpc4", dpc4, 32'h0);
        chk("wrap_addr", imem.imem_addr, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd11);
        chk("perf_squash2", perf_squash, 32'd4);
`endif

        // reset asserted while a fetch is outstanding
        ready = 1'b0;
        step();
        chk("mid_busy", {31'd0, fetch_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_dvalid", {31'd0, dvalid}, 32'd0);
        step();
        resetn = 1'b1;
        ready = 1'b1;
        step();
        chk("restart_req", {31'd0, imem.imem_req}, 32'd1);
        chk("restart_addr", imem.imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
